// File: rtl/spi_host_fifo_if.sv
// Host register-bus and spi_master handshake bundle for spi_host_fifo.
// slave = feeder side, master = host/spi_master side.
interface spi_host_fifo_if #(
  parameter int NUM_TARGETS = 1
);
  logic                   host_cs_en;
  logic [NUM_TARGETS-1:0] host_target;
  logic [7:0]             host_wdata;
  logic                   host_wr;
  logic                   host_rd;
  logic [7:0]             host_rdata;
  logic                   status_clr;
  logic                   tx_full;
  logic                   tx_empty;
  logic                   rx_empty;
  logic                   tx_ovf;
  logic                   rx_ovr;
  logic                   busy;
  logic [NUM_TARGETS-1:0] target_id;
  logic                   target_en;
  logic [7:0]             tx_byte;
  logic                   tx_en;
  logic                   tx_ready;
  logic [7:0]             rx_byte;
  logic                   rx_en;

  modport slave (
    input  host_cs_en, host_target, host_wdata,
    input  host_wr, host_rd, status_clr,
    input  tx_ready, rx_byte, rx_en,
    output host_rdata, tx_full, tx_empty,
    output rx_empty, tx_ovf, rx_ovr, busy,
    output target_id, target_en, tx_byte, tx_en
  );

  modport master (
    output host_cs_en, host_target, host_wdata,
    output host_wr, host_rd, status_clr,
    output tx_ready, rx_byte, rx_en,
    input  host_rdata, tx_full, tx_empty,
    input  rx_empty, tx_ovf, rx_ovr, busy,
    input  target_id, target_en, tx_byte, tx_en
  );
endinterface

// File: rtl/spi_host_fifo.sv
// Host-side TX/RX byte FIFOs and chip-select sequencing
// feeding spi_master over its tx_en/tx_ready/rx_en handshake.
module spi_host_fifo #(
  parameter int NUM_TARGETS = 1,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  spi_host_fifo_if.slave bus
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [7:0]             tx_mem [TX_DEPTH];
  logic [TAW:0]           tx_wp, tx_rp;
  logic [7:0]             rx_mem [RX_DEPTH];
  logic [RAW:0]           rx_wp, rx_rp;
  logic [1:0]             inflight;
  logic                   tx_en_q;
  logic [7:0]             tx_byte_q;
  logic [NUM_TARGETS-1:0] tid_q;
  logic                   tx_ovf_q, rx_ovr_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic issue, tx_push, tx_drop;
  logic rx_pop, rx_push, rx_drop;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) &&
                    (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) &&
                    (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);

  // tx_en_q enforces the idle cycle spi_master needs to drop tx_ready
  assign issue   = (state != IDLE) && !tx_empty &&
                   bus.tx_ready && !tx_en_q;
  assign tx_push = bus.host_wr && (!tx_full || issue);
  assign tx_drop = bus.host_wr && tx_full && !issue;
  assign rx_pop  = bus.host_rd && !rx_empty;
  assign rx_push = bus.rx_en && (!rx_full || rx_pop);
  assign rx_drop = bus.rx_en && rx_full && !rx_pop;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.host_cs_en) state_nx = ACTIVE;
      ACTIVE:  if (!bus.host_cs_en) state_nx = DRAIN;
      DRAIN: begin
        if (bus.host_cs_en)
          state_nx = ACTIVE;
        else if (tx_empty && inflight == 2'd0 && bus.tx_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tid_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.host_cs_en)
        tid_q <= bus.host_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
      for (int i = 0; i < TX_DEPTH; i++)
        tx_mem[i] <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp[TAW-1:0]] <= bus.host_wdata;
        tx_wp <= tx_wp + (TAW+1)'(1);
      end
      if (issue)
        tx_rp <= tx_rp + (TAW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_en_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      tx_en_q <= issue;
      if (issue)
        tx_byte_q <= tx_mem[tx_rp[TAW-1:0]];
    end
  end

  // counted at issue so a byte on the wire is never seen as idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      unique case ({issue, bus.rx_en})
        2'b10:   if (inflight != 2'd3) inflight <= inflight + 2'd1;
        2'b01:   if (inflight != 2'd0) inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp <= '0;
      rx_rp <= '0;
      for (int i = 0; i < RX_DEPTH; i++)
        rx_mem[i] <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wp[RAW-1:0]] <= bus.rx_byte;
        rx_wp <= rx_wp + (RAW+1)'(1);
      end
      if (rx_pop)
        rx_rp <= rx_rp + (RAW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ovf_q <= 1'b0;
      rx_ovr_q <= 1'b0;
    end else if (bus.status_clr) begin
      tx_ovf_q <= 1'b0;
      rx_ovr_q <= 1'b0;
    end else begin
      if (tx_drop) tx_ovf_q <= 1'b1;
      if (rx_drop) rx_ovr_q <= 1'b1;
    end
  end

  assign bus.host_rdata = rx_mem[rx_rp[RAW-1:0]];
  assign bus.tx_full    = tx_full;
  assign bus.tx_empty   = tx_empty;
  assign bus.rx_empty   = rx_empty;
  assign bus.tx_ovf     = tx_ovf_q;
  assign bus.rx_ovr     = rx_ovr_q;
  assign bus.busy       = (state != IDLE);
  assign bus.target_en  = (state != IDLE);
  assign bus.target_id  = tid_q;
  assign bus.tx_byte    = tx_byte_q;
  assign bus.tx_en      = tx_en_q;
endmodule

// File: tb/tb_spi_host_fifo.sv
// Scoreboard bench for spi_host_fifo with a loopback spi_master model.
// Stimulus after posedge, monitors sample on negedge.
module tb_spi_host_fifo;
  logic clk;
  logic reset;

  spi_host_fifo_if #(.NUM_TARGETS(1)) bus ();

  spi_host_fifo #(
    .NUM_TARGETS(1),
    .TX_DEPTH(4),
    .RX_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  logic       stall = 1'b0;
  int         rx_cnt = 0;
  int         inj_seq = 0;
  int         inj_done = 0;
  logic [7:0] inj_byte = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic to_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout at %0t", nm, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.host_wr    = 1'b1;
    bus.host_wdata = b;
    tick();
    bus.host_wr    = 1'b0;
  endtask

  task automatic rd(input logic [7:0] exp);
    rxq.push_back(exp);
    bus.host_rd = 1'b1;
    tick();
    bus.host_rd = 1'b0;
  endtask

  task automatic inject(input logic [7:0] b);
    inj_byte = b;
    inj_seq++;
    tick();
  endtask

  task automatic wait_for(input int sel, input int budget,
                          input string nm);
    int  k;
    bit  ok;
    k  = 0;
    ok = 1'b0;
    while (!ok && k < budget) begin
      case (sel)
        0:       ok = !bus.rx_empty;
        1:       ok = !bus.busy;
        default: ok = 1'b1;
      endcase
      if (!ok) begin
        tick();
        k++;
      end
    end
    if (!ok) to_fail(nm);
  endtask

  // spi_master model: MISO looped to MOSI, 3-cycle transfer
  initial begin : spi_model
    int         cnt;
    logic [7:0] sh;
    cnt          = 0;
    sh           = 8'h00;
    bus.tx_ready = 1'b1;
    bus.rx_en    = 1'b0;
    bus.rx_byte  = 8'h00;
    forever begin
      @(negedge clk);
      bus.rx_en = 1'b0;
      if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.rx_en   = 1'b1;
          bus.rx_byte = sh;
          rx_cnt++;
        end
      end else if (bus.tx_en && !reset) begin
        sh  = bus.tx_byte;
        cnt = 3;
      end else if (inj_seq != inj_done) begin
        bus.rx_en   = 1'b1;
        bus.rx_byte = inj_byte;
        inj_done    = inj_seq;
      end
      bus.tx_ready = (cnt == 0) && !stall;
    end
  end

  initial begin : mon_tx
    logic       prev;
    logic [7:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_en) begin
        chk("tx_gap", {31'd0, prev}, 32'd0);
        if (txq.size() == 0) begin
          chk("tx_unexpected", {24'd0, bus.tx_byte}, 32'hFFFF);
        end else begin
          e = txq.pop_front();
          chk("tx_byte", {24'd0, bus.tx_byte}, {24'd0, e});
        end
      end
      prev = bus.tx_en;
    end
  end

  initial begin : mon_rx
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.host_rd && !bus.rx_empty) begin
        if (rxq.size() == 0) begin
          chk("rx_unexpected", {24'd0, bus.host_rdata}, 32'hFFFF);
        end else begin
          e = rxq.pop_front();
          chk("host_rdata", {24'd0, bus.host_rdata}, {24'd0, e});
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int rx0;
    reset           = 1'b1;
    bus.host_cs_en  = 1'b0;
    bus.host_target = 1'b1;
    bus.host_wdata  = 8'h00;
    bus.host_wr     = 1'b0;
    bus.host_rd     = 1'b0;
    bus.status_clr  = 1'b0;
    tick();
    tick();

    chk("rst_tx_empty",  {31'd0, bus.tx_empty},  32'd1);
    chk("rst_rx_empty",  {31'd0, bus.rx_empty},  32'd1);
    chk("rst_tx_full",   {31'd0, bus.tx_full},   32'd0);
    chk("rst_target_en", {31'd0, bus.target_en}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_tx_en",     {31'd0, bus.tx_en},     32'd0);
    chk("rst_ovf",       {30'd0, bus.tx_ovf, bus.rx_ovr}, 32'd0);
    chk("rst_rdata",     {24'd0, bus.host_rdata}, 32'd0);
    reset = 1'b0;
    tick();

    // reset while draining with two bytes stuck behind tx_ready=0
    stall          = 1'b1;
    bus.host_cs_en = 1'b1;
    tick();
    push(8'hC1);
    push(8'hC2);
    bus.host_cs_en = 1'b0;
    tick();
    tick();
    chk("drain_busy",     {31'd0, bus.busy},      32'd1);
    chk("drain_tx_empty", {31'd0, bus.tx_empty},  32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_target_en", {31'd0, bus.target_en}, 32'd0);
    chk("async_busy",      {31'd0, bus.busy},      32'd0);
    chk("async_tx_empty",  {31'd0, bus.tx_empty},  32'd1);
    tick();
    reset = 1'b0;
    stall = 1'b0;
    tick();

    // single byte loopback
    bus.host_cs_en = 1'b1;
    tick();
    chk("target_en_rise", {31'd0, bus.target_en}, 32'd1);
    chk("target_id",      {31'd0, bus.target_id}, 32'd1);
    txq.push_back(8'hA5);
    push(8'hA5);
    wait_for(0, 40, "wait_rx_a5");
    rd(8'hA5);
    bus.host_cs_en = 1'b0;
    wait_for(1, 40, "wait_idle_a5");

    // four bytes, cs dropped straight after the pushes
    bus.host_cs_en = 1'b1;
    tick();
    rx0 = rx_cnt;
    for (int i = 1; i <= 4; i++) begin
      txq.push_back(8'(i));
      push(8'(i));
    end
    bus.host_cs_en = 1'b0;
    wait_for(1, 200, "wait_idle_4");
    chk("drain_rx_count", 32'(rx_cnt - rx0), 32'd4);
    chk("four_tx_ovf",    {31'd0, bus.tx_ovf}, 32'd0);
    for (int i = 1; i <= 4; i++) rd(8'(i));

    // five pushes while idle into a 4-deep FIFO
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    chk("ovf_tx_full", {31'd0, bus.tx_full}, 32'd1);
    chk("ovf_tx_ovf",  {31'd0, bus.tx_ovf},  32'd1);
    bus.status_clr = 1'b1;
    tick();
    bus.status_clr = 1'b0;
    chk("clr_tx_ovf",  {31'd0, bus.tx_ovf},  32'd0);
    bus.status_clr = 1'b1;
    push(8'h77);
    bus.status_clr = 1'b0;
    chk("clr_wins_tx_ovf", {31'd0, bus.tx_ovf}, 32'd0);
    for (int i = 0; i < 4; i++) txq.push_back(8'(8'h10 + i));
    bus.host_cs_en = 1'b1;
    tick();
    bus.host_cs_en = 1'b0;
    wait_for(1, 200, "wait_idle_ovf");
    chk("ovf_drained", {31'd0, bus.tx_empty}, 32'd1);

    // RX now holds 10..13 and is full
    inject(8'h55);
    chk("rx_ovr_set", {31'd0, bus.rx_ovr}, 32'd1);
    bus.status_clr = 1'b1;
    tick();
    bus.status_clr = 1'b0;
    chk("rx_ovr_clr", {31'd0, bus.rx_ovr}, 32'd0);
    rxq.push_back(8'h10);
    bus.host_rd = 1'b1;
    inject(8'h66);
    bus.host_rd = 1'b0;
    tick();
    chk("rx_ovr_rd_same", {31'd0, bus.rx_ovr}, 32'd0);
    rd(8'h11);
    rd(8'h12);
    rd(8'h13);
    rd(8'h66);

    // read from empty RX: slot 2 last held 0x11
    chk("empty_rx_empty", {31'd0, bus.rx_empty},   32'd1);
    chk("empty_rdata",    {24'd0, bus.host_rdata}, 32'h11);
    bus.host_rd = 1'b1;
    tick();
    bus.host_rd = 1'b0;
    tick();
    chk("empty_rd_rx_empty", {31'd0, bus.rx_empty},   32'd1);
    chk("empty_rd_rdata",    {24'd0, bus.host_rdata}, 32'h11);

    repeat (4) tick();
    chk("txq_drained", 32'(txq.size()), 32'd0);
    chk("rxq_drained", 32'(rxq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
